dzcpu_useq: RTL

Microcode sequencer for the dzcpu core. Sits between opcode fetch and the microcode LUT/ROM pair.
- Presents each fetched opcode byte to the main and CB lookup tables.
- Loads the returned flow index into a micro-PC, then steps the microcode ROM one word per cycle until an end-of-flow code.
- Drives PC-increment, flag-update, CB-prefix and interrupt-entry sequencing for the datapath.

---
 rtl/dzcpu_useq_if.sv | 42 ++++
 rtl/dzcpu_useq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dzcpu_useq_if.sv
// Sequencer <-> fetch/LUT/ROM/datapath signal bundle for dzcpu_useq.
// oWdtErr exists only when DZCPU_USEQ_WATCHDOG_EN is defined.
interface dzcpu_useq_if;
  logic       iStall;
  logic [7:0] iMemData;
  logic [7:0] iLutIdx;
  logic [7:0] iCbLutIdx;
  logic [3:0] iUopFlow;
  logic       iFlagZ;
  logic       iIntReq;
  logic       iIme;
  logic [7:0] oLutMop;
  logic [7:0] oUopAddr;
  logic       oExecute;
  logic       oPcInc;
  logic       oFlagsUpdate;
  logic       oIntAck;
  logic [7:0] oOpcode;
  logic       oCbMode;
  logic [2:0] oState;
`ifdef DZCPU_USEQ_WATCHDOG_EN
  logic       oWdtErr;
`endif

  modport master (
    output iStall, iMemData, iLutIdx, iCbLutIdx, iUopFlow, iFlagZ, iIntReq, iIme,
    input  oLutMop, oUopAddr, oExecute, oPcInc, oFlagsUpdate, oIntAck, oOpcode,
           oCbMode, oState
`ifdef DZCPU_USEQ_WATCHDOG_EN
    , input oWdtErr
`endif
  );

  modport slave (
    input  iStall, iMemData, iLutIdx, iCbLutIdx, iUopFlow, iFlagZ, iIntReq, iIme,
    output oLutMop, oUopAddr, oExecute, oPcInc, oFlagsUpdate, oIntAck, oOpcode,
           oCbMode, oState
`ifdef DZCPU_USEQ_WATCHDOG_EN
    , output oWdtErr
`endif
  );
endinterface

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: opcode -> LUT -> micro-PC -> ROM stepping to end-of-flow.
// Define DZCPU_USEQ_WATCHDOG_EN to add the per-flow uop watchdog and HALTED state.
module dzcpu_useq #(
  parameter logic [7:0]  INT_FLOW_IDX = 8'd220,
  parameter int unsigned MAX_FLOW_LEN = 32
) (
  input logic          iClock,
  input logic          iReset,
  dzcpu_useq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_CB_DECODE = 3'd3,
    S_INT_ENTRY = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] upc_q, upc_d;
  logic [7:0] opc_q, opc_d;
  logic       cb_q, cb_d;
  logic       cbpend_q, cbpend_d;

  logic       exec;
  logic       flow_inc, flow_fu, flow_end, flow_jcb;

`ifdef DZCPU_USEQ_WATCHDOG_EN
  logic [5:0] wdt_q, wdt_d;
`else
  localparam int unsigned unused_max_flow_len = MAX_FLOW_LEN;
`endif

  always_comb begin
    exec     = (state_q == S_EXEC) && !bus.iStall;
    flow_inc = 1'b0;
    flow_fu  = 1'b0;
    flow_end = 1'b0;
    flow_jcb = 1'b0;
    case (bus.iUopFlow)
      4'd1: flow_inc = 1'b1;
      4'd2: flow_end = 1'b1;
      4'd3: begin flow_inc = 1'b1; flow_end = 1'b1; end
      4'd4: begin flow_fu  = 1'b1; flow_end = 1'b1; end
      4'd5: begin flow_inc = 1'b1; flow_fu = 1'b1; flow_end = 1'b1; end
      4'd6: begin flow_inc = 1'b1; flow_end = bus.iFlagZ; end
      4'd7: begin flow_inc = 1'b1; flow_end = !bus.iFlagZ; end
      4'd8: begin flow_inc = 1'b1; flow_jcb = 1'b1; end
      4'd9: flow_fu = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    opc_d    = opc_q;
    cb_d     = cb_q;
    cbpend_d = cbpend_q;
`ifdef DZCPU_USEQ_WATCHDOG_EN
    wdt_d    = wdt_q;
`endif
    if (!bus.iStall) begin
      case (state_q)
        S_FETCH: begin
          state_d  = cbpend_q ? S_CB_DECODE : S_DECODE;
          cbpend_d = 1'b0;
        end
        S_DECODE: begin
          opc_d   = bus.iMemData;
          cb_d    = 1'b0;
          upc_d   = bus.iLutIdx;
          state_d = S_EXEC;
`ifdef DZCPU_USEQ_WATCHDOG_EN
          wdt_d   = '0;
`endif
        end
        S_CB_DECODE: begin
          opc_d   = bus.iMemData;
          cb_d    = 1'b1;
          upc_d   = bus.iCbLutIdx;
          state_d = S_EXEC;
`ifdef DZCPU_USEQ_WATCHDOG_EN
          wdt_d   = '0;
`endif
        end
        S_INT_ENTRY: begin
          upc_d   = INT_FLOW_IDX;
          cb_d    = 1'b0;
          state_d = S_EXEC;
`ifdef DZCPU_USEQ_WATCHDOG_EN
          wdt_d   = '0;
`endif
        end
        S_EXEC: begin
          // jcb is not an end: no interrupt sampling, the CB byte must follow
          if (flow_jcb) begin
            state_d  = S_FETCH;
            cbpend_d = 1'b1;
          end else if (flow_end) begin
            state_d = (bus.iIntReq && bus.iIme) ? S_INT_ENTRY : S_FETCH;
          end else begin
            upc_d = upc_q + 8'd1;
`ifdef DZCPU_USEQ_WATCHDOG_EN
            if ((32'(wdt_q) + 32'd1) >= MAX_FLOW_LEN) state_d = S_HALTED;
`endif
          end
`ifdef DZCPU_USEQ_WATCHDOG_EN
          wdt_d = wdt_q + 6'd1;
`endif
        end
`ifdef DZCPU_USEQ_WATCHDOG_EN
        S_HALTED: ;
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q  <= S_FETCH;
      upc_q    <= '0;
      opc_q    <= '0;
      cb_q     <= 1'b0;
      cbpend_q <= 1'b0;
`ifdef DZCPU_USEQ_WATCHDOG_EN
      wdt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      upc_q    <= upc_d;
      opc_q    <= opc_d;
      cb_q     <= cb_d;
      cbpend_q <= cbpend_d;
`ifdef DZCPU_USEQ_WATCHDOG_EN
      wdt_q    <= wdt_d;
`endif
    end
  end

  assign bus.oLutMop      = bus.iMemData;
  assign bus.oUopAddr     = upc_q;
  assign bus.oExecute     = exec;
  assign bus.oPcInc       = exec && flow_inc;
  assign bus.oFlagsUpdate = exec && flow_fu;
  assign bus.oIntAck      = (state_q == S_INT_ENTRY) && !bus.iStall;
  assign bus.oOpcode      = opc_q;
  assign bus.oCbMode      = cb_q;
  assign bus.oState       = state_q;
`ifdef DZCPU_USEQ_WATCHDOG_EN
  assign bus.oWdtErr      = (state_q == S_HALTED);
`endif

endmodule
